// File: rtl/pipe_latch_de.sv
// D->E pipeline latch as a two-entry skid buffer: registered in_ready, flush
// via CLR, and saturating stall/flush statistics counters.
module pipe_latch_de #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int ALUC_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CLR,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              RegWriteD,
    input  logic              RegDstD,
    input  logic              AluSrcD,
    input  logic              MemWriteD,
    input  logic              MemtoRegD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic [DATA_W-1:0] RD1,
    input  logic [DATA_W-1:0] RD2,
    input  logic [DATA_W-1:0] SignimmD,
    input  logic [REG_W-1:0]  RsD,
    input  logic [REG_W-1:0]  RtD,
    input  logic [REG_W-1:0]  RdD,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              RegWriteE,
    output logic              RegDstE,
    output logic              AluSrcE,
    output logic              MemWriteE,
    output logic              MemtoRegE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] SignimmE,
    output logic [REG_W-1:0]  RsE,
    output logic [REG_W-1:0]  RtE,
    output logic [REG_W-1:0]  RdE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              reg_write;
        logic              reg_dst;
        logic              alu_src;
        logic              mem_write;
        logic              mem_to_reg;
        logic [ALUC_W-1:0] alu_control;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] signimm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t  state, state_nxt;
    bundle_t main_q, skid_q, in_b;
    logic    accept, consume;
    logic    load_main, load_skid, skid_to_main;

    assign in_b = {RegWriteD, RegDstD, AluSrcD, MemWriteD, MemtoRegD, ALUControlD,
                   RD1, RD2, SignimmD, RsD, RtD, RdD};

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_nxt    = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end else if (consume) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    skid_to_main = 1'b1;
                    state_nxt    = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // in_ready is the registered image of "next state is not TWO", so it never
    // depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (rst || CLR) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != TWO);
            if (load_main)
                main_q <= in_b;
            else if (skid_to_main)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= in_b;
        end
    end

    // Statistics survive CLR; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (CLR && (state != EMPTY) && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign RegWriteE   = main_q.reg_write;
    assign RegDstE     = main_q.reg_dst;
    assign AluSrcE     = main_q.alu_src;
    assign MemWriteE   = main_q.mem_write;
    assign MemtoRegE   = main_q.mem_to_reg;
    assign ALUControlE = main_q.alu_control;
    assign RD1E        = main_q.rd1;
    assign RD2E        = main_q.rd2;
    assign SignimmE    = main_q.signimm;
    assign RsE         = main_q.rs;
    assign RtE         = main_q.rt;
    assign RdE         = main_q.rd;

endmodule

// File: tb/tb_pipe_latch_de.sv
// Bench for pipe_latch_de: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_pipe_latch_de;

    typedef logic [118:0] bv_t;

    logic clk = 1'b0;
    logic rst, CLR, in_valid, out_ready;
    logic RegWriteD, RegDstD, AluSrcD, MemWriteD, MemtoRegD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1, RD2, SignimmD;
    logic [4:0]  RsD, RtD, RdD;

    logic        in_ready, out_valid;
    logic        RegWriteE, RegDstE, AluSrcE, MemWriteE, MemtoRegE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, SignimmE;
    logic [4:0]  RsE, RtE, RdE;
    logic [15:0] stall_cnt, flush_cnt;

    logic        in_ready4, out_valid4;
    logic        RegWriteE4, RegDstE4, AluSrcE4, MemWriteE4, MemtoRegE4;
    logic [2:0]  ALUControlE4;
    logic [31:0] RD1E4, RD2E4, SignimmE4;
    logic [4:0]  RsE4, RtE4, RdE4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_latch_de dut (
        .clk(clk), .rst(rst), .CLR(CLR), .in_valid(in_valid), .in_ready(in_ready),
        .RegWriteD(RegWriteD), .RegDstD(RegDstD), .AluSrcD(AluSrcD),
        .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD), .ALUControlD(ALUControlD),
        .RD1(RD1), .RD2(RD2), .SignimmD(SignimmD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .out_valid(out_valid), .out_ready(out_ready),
        .RegWriteE(RegWriteE), .RegDstE(RegDstE), .AluSrcE(AluSrcE),
        .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .SignimmE(SignimmE), .RsE(RsE), .RtE(RtE), .RdE(RdE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_latch_de #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .CLR(CLR), .in_valid(in_valid), .in_ready(in_ready4),
        .RegWriteD(RegWriteD), .RegDstD(RegDstD), .AluSrcD(AluSrcD),
        .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD), .ALUControlD(ALUControlD),
        .RD1(RD1), .RD2(RD2), .SignimmD(SignimmD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .out_valid(out_valid4), .out_ready(out_ready),
        .RegWriteE(RegWriteE4), .RegDstE(RegDstE4), .AluSrcE(AluSrcE4),
        .MemWriteE(MemWriteE4), .MemtoRegE(MemtoRegE4), .ALUControlE(ALUControlE4),
        .RD1E(RD1E4), .RD2E(RD2E4), .SignimmE(SignimmE4), .RsE(RsE4), .RtE(RtE4), .RdE(RdE4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    bv_t in_vec, e_vec, e4_vec;
    assign in_vec = {RegWriteD, RegDstD, AluSrcD, MemWriteD, MemtoRegD, ALUControlD,
                     RD1, RD2, SignimmD, RsD, RtD, RdD};
    assign e_vec  = {RegWriteE, RegDstE, AluSrcE, MemWriteE, MemtoRegE, ALUControlE,
                     RD1E, RD2E, SignimmE, RsE, RtE, RdE};
    assign e4_vec = {RegWriteE4, RegDstE4, AluSrcE4, MemWriteE4, MemtoRegE4, ALUControlE4,
                     RD1E4, RD2E4, SignimmE4, RsE4, RtE4, RdE4};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every field derived from v so that a mis-routed field shows up; RD1 == v.
    function automatic bv_t mk(input logic [31:0] x);
        logic [2:0] a;
        logic [4:0] s, t, d;
        a = x[2:0] + 3'd1;
        s = x[4:0] | 5'd1;
        t = x[4:0] + 5'd2;
        d = x[4:0] + 5'd3;
        return {x[0], x[1], x[2], x[3], ~x[0], a, x, ~x, x * 32'd3, s, t, d};
    endfunction

    task automatic set_in(input logic [31:0] v);
        {RegWriteD, RegDstD, AluSrcD, MemWriteD, MemtoRegD, ALUControlD,
         RD1, RD2, SignimmD, RsD, RtD, RdD} = mk(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the stage is a FIFO of depth two whose head is the E output.
    bv_t         q[$];
    logic [15:0] m_stall, m_flush;
    logic [3:0]  m_stall4, m_flush4;
    bit          live = 0;
    bit          zeroed = 0;

    always @(posedge clk) begin
        bit cons, acc;
        if (rst) begin
            q.delete();
            m_stall = '0; m_flush = '0; m_stall4 = '0; m_flush4 = '0;
            zeroed = 1; live = 1;
        end else begin
            if (q.size() > 0 && !out_ready) begin
                if (m_stall != 16'hFFFF) m_stall = m_stall + 1;
                if (m_stall4 != 4'hF) m_stall4 = m_stall4 + 1;
            end
            if (CLR) begin
                if (q.size() > 0) begin
                    if (m_flush != 16'hFFFF) m_flush = m_flush + 1;
                    if (m_flush4 != 4'hF) m_flush4 = m_flush4 + 1;
                end
                q.delete();
                zeroed = 1;
            end else begin
                cons = (q.size() > 0) && out_ready;
                acc  = in_valid && (q.size() < 2);
                if (cons) void'(q.pop_front());
                if (acc) begin
                    q.push_back(in_vec);
                    zeroed = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() < 2);
            chk("out_valid4", out_valid4, q.size() > 0);
            chk("in_ready4", in_ready4, q.size() < 2);
            if (q.size() > 0) begin
                chk("e_bundle", e_vec, q[0]);
                chk("e_bundle4", e4_vec, q[0]);
            end else if (zeroed) begin
                chk("e_zero", e_vec, 0);
                chk("e_zero4", e4_vec, 0);
            end
            chk("stall_cnt", stall_cnt, m_stall);
            chk("flush_cnt", flush_cnt, m_flush);
            chk("stall_cnt4", stall_cnt4, m_stall4);
            chk("flush_cnt4", flush_cnt4, m_flush4);
        end
    end

    initial begin
        rst = 1; CLR = 0; in_valid = 0; out_ready = 0;
        set_in(0);

        // reset: two cycles, then release
        tick(); tick();
        rst = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_e_zero", e_vec, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_flush", flush_cnt, 0);
        tick();
        chk("rst_in_ready_after", in_ready, 1);

        // streaming
        out_ready = 1; in_valid = 1;
        for (int i = 1; i <= 8; i++) begin
            set_in(i);
            tick();
            chk("stream_rd1e", RD1E, i);
            chk("stream_valid", out_valid, 1);
            chk("stream_stall", stall_cnt, 0);
        end
        in_valid = 0;
        tick();
        chk("stream_drain", out_valid, 0);

        // backpressure
        out_ready = 0; in_valid = 1;
        set_in(32'h11);
        tick();
        chk("bp_a_rd1e", RD1E, 32'h11);
        chk("bp_a_ready", in_ready, 1);
        chk("bp_a_stall", stall_cnt, 0);
        set_in(32'h22);
        tick();
        chk("bp_b_ready", in_ready, 0);
        chk("bp_b_rd1e", RD1E, 32'h11);
        chk("bp_b_stall", stall_cnt, 1);
        in_valid = 0;
        tick();
        chk("bp_hold_rd1e", RD1E, 32'h11);
        chk("bp_hold_stall2", stall_cnt, 2);
        tick();
        chk("bp_hold_stall3", stall_cnt, 3);
        out_ready = 1;
        tick();
        chk("bp_rel_rd1e", RD1E, 32'h22);
        chk("bp_rel_valid", out_valid, 1);
        chk("bp_rel_ready", in_ready, 1);
        tick();
        chk("bp_done_valid", out_valid, 0);
        chk("bp_done_stall", stall_cnt, 3);

        // flush in TWO with an offered bundle
        out_ready = 0; in_valid = 1;
        set_in(32'h33); tick();
        set_in(32'h44); tick();
        chk("fl_two_ready", in_ready, 0);
        set_in(32'h55); CLR = 1;
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_e_zero", e_vec, 0);
        chk("fl_rse", RsE, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_cnt", flush_cnt, 1);
        CLR = 0; in_valid = 0;
        tick();
        chk("fl_dropped", out_valid, 0);
        CLR = 1;
        tick();
        chk("fl_empty_cnt", flush_cnt, 1);
        CLR = 0;

        // rst and CLR together
        in_valid = 1; set_in(32'h66);
        tick();
        in_valid = 0; rst = 1; CLR = 1;
        tick();
        chk("pr_flush", flush_cnt, 0);
        chk("pr_stall", stall_cnt, 0);
        chk("pr_valid", out_valid, 0);
        chk("pr_e_zero", e_vec, 0);
        rst = 0; CLR = 0;
        tick();

        // saturation: 20 stall cycles on both counter widths
        out_ready = 0; in_valid = 1; set_in(32'h77);
        tick();
        in_valid = 0;
        repeat (20) tick();
        chk("sat_stall4", stall_cnt4, 15);
        chk("sat_stall16", stall_cnt, 20);
        chk("sat_rd1e", RD1E, 32'h77);
        out_ready = 1;
        tick();
        chk("sat_drain", out_valid, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
